// File: rtl/ex_stage_pkg.sv
// Shared encodings for the RV32I execute stage.
// Micro-op opcodes, micro-op classes and the EX sequencing states.
package ex_stage_pkg;

   localparam int RTLOP_W   = 4;
   localparam int RTLTYPE_W = 2;
   localparam int XLEN      = 32;
   localparam int REG_AW    = 5;

   typedef enum logic [RTLOP_W-1:0] {
      RTLOP_ADD  = 4'd0,
      RTLOP_SLL  = 4'd1,
      RTLOP_SLT  = 4'd2,
      RTLOP_SLTU = 4'd3,
      RTLOP_XOR  = 4'd4,
      RTLOP_SHR  = 4'd5,
      RTLOP_OR   = 4'd6,
      RTLOP_AND  = 4'd7,
      RTLOP_SAR  = 4'd13
   } rtlop_e;

   typedef enum logic [RTLTYPE_W-1:0] {
      RTLTYPE_ARICH = 2'd0,
      RTLTYPE_RMEM  = 2'd1,
      RTLTYPE_WMEM  = 2'd2,
      RTLTYPE_JUMP  = 2'd3
   } rtltype_e;

   typedef enum logic {
      ST_EXEC = 1'b0,
      ST_WAIT = 1'b1
   } ex_state_e;

   typedef struct packed {
      logic [RTLOP_W-1:0] op;
      rtltype_e           ty;
      logic [XLEN-1:0]    pc;
      logic [XLEN-1:0]    src1;
      logic [XLEN-1:0]    src2;
      logic [REG_AW-1:0]  waddr;
   } id_ex_t;

   function automatic logic misaligned(input logic [XLEN-1:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational RV32I integer ALU for the execute stage.
// Unknown opcodes produce zero.
module ex_stage_alu
   import ex_stage_pkg::*;
(
   input  logic [RTLOP_W-1:0] rtlop_i,
   input  logic [XLEN-1:0]    src1_i,
   input  logic [XLEN-1:0]    src2_i,
   output logic [XLEN-1:0]    result_o
);

   logic [4:0] shamt;
   logic       lt_s;
   logic       lt_u;

   assign shamt = src2_i[4:0];
   assign lt_s  = $signed(src1_i) < $signed(src2_i);
   assign lt_u  = src1_i < src2_i;

   always_comb begin
      result_o = '0;
      case (rtlop_i)
         RTLOP_ADD:  result_o = src1_i + src2_i;
         RTLOP_SLL:  result_o = src1_i << shamt;
         RTLOP_SLT:  result_o = {31'd0, lt_s};
         RTLOP_SLTU: result_o = {31'd0, lt_u};
         RTLOP_XOR:  result_o = src1_i ^ src2_i;
         RTLOP_SHR:  result_o = src1_i >> shamt;
         RTLOP_OR:   result_o = src1_i | src2_i;
         RTLOP_AND:  result_o = src1_i & src2_i;
         RTLOP_SAR:  result_o = $signed(src1_i) >>> shamt;
         default:    result_o = '0;
      endcase
   end

endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage: ID->EX register, ALU, jump resolution,
// load/store handshake, write-back and forwarding to ID.
module ex_stage
   import ex_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid_i,
   input  logic [RTLOP_W-1:0]   rtlop_i,
   input  logic [RTLTYPE_W-1:0] rtltype_i,
   input  logic [31:0]          pc_i,
   input  logic [31:0]          src1_i,
   input  logic [31:0]          src2_i,
   input  logic [4:0]           gprs_waddr_i,
   output logic                 stall_o,
   output logic                 redirect_o,
   output logic [31:0]          redirect_pc_o,
   output logic [4:0]           ex_gprs_waddr,
   output logic [31:0]          ex_gprs_wdata,
   output logic                 mem_req_o,
   output logic                 mem_we_o,
   output logic [31:0]          mem_addr_o,
   output logic [31:0]          mem_wdata_o,
   input  logic                 mem_gnt_i,
   input  logic                 mem_rvalid_i,
   input  logic [31:0]          mem_rdata_i,
   output logic                 error_o
);

   id_ex_t    ex_q;
   id_ex_t    ex_d;
   logic      ex_valid_q;
   logic      ex_valid_d;
   ex_state_e state_q;
   ex_state_e state_d;

   logic        accept;
   logic        done;
   logic [31:0] alu_res;
   logic [31:0] ls_addr;
   logic [31:0] jmp_tgt;
   logic [31:0] link_pc;
   logic        is_store;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;

   ex_stage_alu u_alu (
      .rtlop_i  (ex_q.op),
      .src1_i   (ex_q.src1),
      .src2_i   (ex_q.src2),
      .result_o (alu_res)
   );

   // Loads add the offset here; stores arrive with the final address.
   assign is_store = ex_q.ty == RTLTYPE_WMEM;
   assign ls_addr  = is_store ? ex_q.src1 : ex_q.src1 + ex_q.src2;
   assign jmp_tgt  = (ex_q.src1 + ex_q.src2) & ~32'd1;
   assign link_pc  = ex_q.pc + 32'd4;

   always_comb begin
      done          = 1'b0;
      state_d       = state_q;
      mem_req_o     = 1'b0;
      mem_we_o      = 1'b0;
      mem_addr_o    = '0;
      mem_wdata_o   = '0;
      error_o       = 1'b0;
      redirect_o    = 1'b0;
      redirect_pc_o = RESET_PC;
      wb_addr       = '0;
      wb_data       = '0;
      if (ex_valid_q) begin
         unique case (state_q)
            ST_EXEC: begin
               unique case (ex_q.ty)
                  RTLTYPE_ARICH: begin
                     done    = 1'b1;
                     wb_addr = ex_q.waddr;
                     wb_data = alu_res;
                  end
                  RTLTYPE_JUMP: begin
                     done          = 1'b1;
                     redirect_o    = 1'b1;
                     redirect_pc_o = jmp_tgt;
                     wb_addr       = ex_q.waddr;
                     wb_data       = link_pc;
                  end
                  RTLTYPE_RMEM, RTLTYPE_WMEM: begin
                     if (misaligned(ls_addr)) begin
                        done    = 1'b1;
                        error_o = 1'b1;
                     end else begin
                        mem_req_o   = 1'b1;
                        mem_we_o    = is_store;
                        mem_addr_o  = ls_addr;
                        mem_wdata_o = is_store ? ex_q.src2 : '0;
                        if (mem_gnt_i) begin
                           if (is_store) begin
                              done = 1'b1;
                           end else if (mem_rvalid_i) begin
                              done    = 1'b1;
                              wb_addr = ex_q.waddr;
                              wb_data = mem_rdata_i;
                           end else begin
                              state_d = ST_WAIT;
                           end
                        end
                     end
                  end
               endcase
            end
            ST_WAIT: begin
               if (mem_rvalid_i) begin
                  done    = 1'b1;
                  wb_addr = ex_q.waddr;
                  wb_data = mem_rdata_i;
                  state_d = ST_EXEC;
               end
            end
         endcase
      end
      ex_gprs_waddr = wb_addr;
      ex_gprs_wdata = (wb_addr == 5'd0) ? 32'd0 : wb_data;
   end

   assign stall_o = ex_valid_q & ~done;
   assign accept  = in_valid_i & ~stall_o & ~redirect_o;

   always_comb begin
      ex_d       = ex_q;
      ex_valid_d = ex_valid_q;
      if (accept) begin
         ex_d.op    = rtlop_i;
         ex_d.ty    = rtltype_e'(rtltype_i);
         ex_d.pc    = pc_i;
         ex_d.src1  = src1_i;
         ex_d.src2  = src2_i;
         ex_d.waddr = gprs_waddr_i;
         ex_valid_d = 1'b1;
      end else if (done) begin
         ex_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q       <= '0;
         ex_valid_q <= 1'b0;
         state_q    <= ST_EXEC;
      end else begin
         ex_q       <= ex_d;
         ex_valid_q <= ex_valid_d;
         state_q    <= state_d;
      end
   end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the RV32I core; consumes the decoded micro-op (rtlop/rtltype/pc/src1/src2/waddr) produced by instruction decode.
- Holds the ID→EX pipeline register, runs the ALU, resolves jumps and drives a word-wide memory request/response handshake for loads and stores.
- Produces the GPRS write-back and the EX→ID forwarding pair (ex_gprs_waddr/ex_gprs_wdata), plus stall and PC-redirect to IF/ID.

Parameters:
- RESET_PC, 32'h0000_0000, value driven on redirect_pc_o while idle/reset; no functional effect.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid_i  in  1  ID presents a micro-op
- rtlop_i  in  `RTLOP_BUS (4)  ALU op
- rtltype_i  in  `RTLTYPE_BUS (2)  ARICH/RMEM/WMEM/JUMP
- pc_i  in  32  instruction PC
- src1_i  in  32  operand 1 (store: final address)
- src2_i  in  32  operand 2 (store: store data)
- gprs_waddr_i  in  5  destination reg, x0 = none
- stall_o  out  1  EX busy; IF/ID must hold
- redirect_o  out  1  jump taken this cycle; flush ID
- redirect_pc_o  out  32  jump target
- ex_gprs_waddr  out  5  forward/write-back address (x0 when nothing to write)
- ex_gprs_wdata  out  32  forward/write-back data
- mem_req_o, mem_we_o  out  1  memory request, write enable
- mem_addr_o, mem_wdata_o  out  32  word address, store data
- mem_gnt_i, mem_rvalid_i  in  1  request accepted, read data valid
- mem_rdata_i  in  32  load data
- error_o  out  1  misaligned access, one-cycle pulse

Behaviour:
- Reset (async, rst_n low): ex_valid=0, state=EXEC, latched fields zero; all outputs 0 except redirect_pc_o=RESET_PC. An in-flight mem_req_o drops immediately; a pending rvalid after reset is ignored.
- accept = in_valid_i & ~stall_o & ~redirect_o; on accept, latch all ID fields and set ex_valid. When done & ~accept, clear ex_valid.
- State EXEC (ex_valid):
  - ARICH: done this cycle.
  - JUMP: done this cycle.
  - RMEM/WMEM: drive mem_req_o with fields held stable until mem_gnt_i. On gnt: store is done; load moves to WAIT.
- State WAIT: load done on mem_rvalid_i, then back to EXEC.
- done and stall_o are combinational: stall_o = ex_valid & ~done.
- ALU result (ARICH):
  - ADD src1+src2; SLL src1<<src2[4:0].
  - SLT signed, SLTU unsigned (result 0/1).
  - XOR, OR, AND.
  - SHR logical, SAR arithmetic, shift amount src2[4:0]. Wrap-around modulo 2^32.
  - Undefined rtlop yields 0.
- Address:
  - RMEM: mem_addr_o = src1+src2.
  - WMEM: mem_addr_o = src1; mem_wdata_o = src2; mem_we_o=1.
  - addr[1:0]≠0: no request; error_o pulses; instruction retires without write-back.
- JUMP:
  - redirect_o=1 and redirect_pc_o=(src1+src2)&~1 in the done cycle.
  - Write-back value pc+4 to waddr; taken branches carry waddr x0.
  - The micro-op presented by ID in that cycle is discarded.
- Write-back/forward:
  - ex_gprs_waddr = latched waddr only in the done cycle of ARICH/RMEM/JUMP; otherwise x0. GPRS writes at that clock edge.
  - ex_gprs_wdata = ALU result, mem_rdata_i, or pc+4; 0 when waddr=x0.
- Simultaneous events:
  - gnt and rvalid in the same cycle as req is legal: the load completes in EXEC without entering WAIT.
  - accept in the done cycle gives back-to-back issue with no bubble.

Decomposition:
- `RTLOP_*` (ADD 0, SLL 1, SLT 2, SLTU 3, XOR 4, SHR 5, OR 6, AND 7, SAR 13) go in common.v.
- `RTLTYPE_*` (ARICH 0, RMEM 1, WMEM 2, JUMP 3) and the bus widths go in common.v.
- Local state encodings EXEC/WAIT stay in common.v beside them.
- One sub-module, alu: purely combinational (rtlop, src1, src2 → result).

Test Plan:
- ARICH ADD src1=32'hFFFF_FFFF, src2=1, waddr=5 → same cycle ex_gprs_waddr=5, wdata=0, stall_o=0.
- SAR src1=32'h8000_0000, src2=4 → wdata=32'hF800_0000. SLT src1=-1, src2=1 → 1; SLTU same operands → 0.
- Load src1=32'h100, src2=4; gnt after 2 cycles, rvalid 3 cycles later with rdata=32'hDEAD_BEEF:
  - req and addr 32'h104 held stable; stall_o high 5 cycles.
  - On the done cycle, waddr/wdata forwarded once.
- Store src1=32'h200, src2=32'h1234, gnt same cycle → one-cycle req with we=1, no write-back, no stall. Repeat with src1=32'h202 → error_o pulse, no req.
- JAL pc=32'h40, src1=32'h40, src2=32'h10, waddr=1:
  - redirect_o=1, redirect_pc_o=32'h50, wdata=32'h44.
  - Next ID op (in_valid_i high) not latched.
- rst_n low while in WAIT → mem_req_o and stall_o drop asynchronously. A late rvalid after release produces no write-back.
